// File: rtl/spi_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_mem_pkg                                            |
// | Description : Shared opcodes, size encodings, FSM states and helpers |
// |               for the serial memory controller.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package spi_mem_pkg;

    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h02;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Number of data bytes carried by a request; 0 for the illegal encoding.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_sck_gen                                            |
// | Description : Divides clk into a mode-0 SCK (idle low) and flags the |
// |               cycle before each SCK rise and fall.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module spi_sck_gen import spi_mem_pkg::*; #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise_stb,
    output logic o_fall_stb
);

    localparam int               c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_sck;
    logic               w_half_done;

    // A half-period ends on the last count; the strobes mark the edge that toggles SCK.
    assign w_half_done = i_en && (r_cnt == c_last);
    assign o_rise_stb  = w_half_done && !r_sck;
    assign o_fall_stb  = w_half_done && r_sck;
    assign o_sck       = r_sck;

    // Half-period counter; disabled means parked low with the count cleared.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_half_done) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : spi_mem_ctrl                                           |
// | Description : Mode-0 SPI master for serial PSRAM/flash. One byte,    |
// |               half or word per request, little-endian data, per-     |
// |               device read-only protection and error response.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module spi_mem_ctrl import spi_mem_pkg::*; #(
    parameter int                 NUM_DEV = 2,
    parameter int                 ADDR_W  = 24,
    parameter int                 CLK_DIV = 2,
    parameter logic [NUM_DEV-1:0] RO_MASK = NUM_DEV'(2)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic                                      req_we,
    input  logic [1:0]                                req_size,
    input  logic [((NUM_DEV > 1) ? $clog2(NUM_DEV) : 1)-1:0] req_dev,
    input  logic [ADDR_W-1:0]                         req_addr,
    input  logic [31:0]                               req_wdata,
    output logic                                      rsp_valid,
    output logic [31:0]                               rsp_rdata,
    output logic                                      rsp_err,
    output logic                                      spi_sck,
    output logic [NUM_DEV-1:0]                        spi_cs_n,
    output logic                                      spi_mosi,
    input  logic [NUM_DEV-1:0]                        spi_miso
);

    localparam int c_dev_w   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int c_hdr_w   = 8 + ADDR_W;
    localparam int c_frame_w = c_hdr_w + 32;
    localparam int c_cnt_w   = $clog2(c_frame_w + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_we;
    logic [c_dev_w-1:0]   r_dev;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_nbits;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [c_frame_w-1:0] r_tx;
    logic                 r_mosi;
    logic [31:0]          r_rx;

    logic                 w_accept;
    logic                 w_dev_ok;
    logic                 w_ro_hit;
    logic                 w_req_err;
    logic [2:0]           w_bytes;
    logic [c_cnt_w-1:0]   w_nbits;
    logic [31:0]          w_data_mask;
    logic [31:0]          w_wdata_seq;
    logic [c_frame_w-1:0] w_frame;
    logic [NUM_DEV-1:0]   w_cs_sel;
    logic                 w_miso;
    logic                 w_sck;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_last;
    logic [4:0]           w_rx_pos;

    spi_sck_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_sck_gen (
        .clk        (clk),
        .rst        (reset),
        .i_en       (r_state == ST_SHIFT),
        .o_sck      (w_sck),
        .o_rise_stb (w_rise),
        .o_fall_stb (w_fall)
    );

    // Request decode: legality, frame length and the serialised frame image.
    always_comb begin
        w_dev_ok = 1'b0;
        w_ro_hit = 1'b0;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (req_dev == c_dev_w'(d)) begin
                w_dev_ok = 1'b1;
                w_ro_hit = RO_MASK[d];
            end
        end
        w_req_err = (req_size == SIZE_BAD) || !w_dev_ok || (req_we && w_ro_hit);
        w_accept  = req_valid && req_ready;
        w_bytes   = size_to_bytes(req_size);
        w_nbits   = c_cnt_w'(c_hdr_w) + c_cnt_w'({w_bytes, 3'b000});
        case (req_size)
            SIZE_BYTE: w_data_mask = 32'hFF00_0000;
            SIZE_HALF: w_data_mask = 32'hFFFF_0000;
            default:   w_data_mask = 32'hFFFF_FFFF;
        endcase
        // Byte 0 goes first on the wire, so the bytes are reversed into the MSB-first stream.
        w_wdata_seq = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]}
                      & w_data_mask & {32{req_we}};
        w_frame     = {(req_we ? OP_WRITE : OP_READ), req_addr, w_wdata_seq};
    end

    // Selected-device decode, MISO mux, last-bit detect and receive bit position.
    always_comb begin
        for (int d = 0; d < NUM_DEV; d++) begin
            w_cs_sel[d] = (r_dev == c_dev_w'(d));
        end
        w_miso   = |(spi_miso & w_cs_sel);
        w_last   = w_fall && (r_bit_cnt == r_nbits - 1'b1);
        // Data bit k lands in byte k/8 at position 7-(k%8): flip the low three index bits.
        w_rx_pos = 5'(r_bit_cnt - c_cnt_w'(c_hdr_w)) ^ 5'b00111;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: illegal requests skip the frame and answer straight away.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = w_req_err ? ST_RESP : ST_SHIFT;
            ST_SHIFT: if (w_last)   w_state_next = ST_RESP;
            ST_RESP:                w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; read data is shown only on a good read response.
    always_comb begin
        req_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
        rsp_err   = rsp_valid && r_err;
        rsp_rdata = (rsp_valid && !r_err && !r_we) ? r_rx : 32'h0;
        spi_cs_n  = (r_state == ST_SHIFT) ? ~w_cs_sel : '1;
        spi_sck   = w_sck;
        spi_mosi  = r_mosi;
    end

    // Datapath: capture at acceptance, shift MOSI after each fall, sample MISO at each rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we      <= 1'b0;
            r_dev     <= '0;
            r_err     <= 1'b0;
            r_nbits   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_mosi    <= 1'b0;
            r_rx      <= '0;
        end else if (w_accept) begin
            r_we      <= req_we;
            r_dev     <= req_dev;
            r_err     <= w_req_err;
            r_nbits   <= w_nbits;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            if (w_req_err) begin
                r_tx   <= '0;
                r_mosi <= 1'b0;
            end else begin
                r_tx   <= w_frame << 1;
                r_mosi <= w_frame[c_frame_w-1];
            end
        end else if (r_state == ST_SHIFT) begin
            if (w_rise && !r_we && (r_bit_cnt >= c_cnt_w'(c_hdr_w))) begin
                r_rx[w_rx_pos] <= w_miso;
            end
            if (w_fall) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_tx      <= r_tx << 1;
                r_mosi    <= w_last ? 1'b0 : r_tx[c_frame_w-1];
            end
        end
    end

endmodule
`default_nettype wire
